// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared widths, FSM state encoding and saturating counter helper
package hazard_ctrl_pkg;
  localparam int ISA_WIDTH = 32;
  localparam int REG_ADDR_WIDTH = 5;
  typedef logic [ISA_WIDTH-1:0] isa_word_t;
  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_MDU_BUSY = 2'd1,
    HZ_MDU_DONE = 2'd2
  } hz_state_e;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side signals of the hazard sequencer; stats ports exist only with HAZARD_STATS_EN
interface hazard_ctrl_if
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) ();
  logic                 id_no_op;
  reg_addr_t            id_rs;
  reg_addr_t            id_rt;
  logic                 id_uses_rs;
  logic                 id_uses_rt;
  logic                 ex_mem_read;
  logic                 ex_reg_write;
  reg_addr_t            ex_rd;
  logic                 ex_mdu_op;
  logic                 pc_offset;
  logic                 pc_hold;
  logic                 if_hold;
  logic                 id_bubble;
  logic                 ex_hold;
  logic                 mdu_busy;
  logic [CNT_WIDTH-1:0] mdu_remaining;
`ifdef HAZARD_STATS_EN
  logic [31:0]          stat_lu_stalls;
  logic [31:0]          stat_mdu_stalls;
  logic [31:0]          stat_flushes;
`endif
  modport slave (
    input  id_no_op, id_rs, id_rt, id_uses_rs, id_uses_rt,
    input  ex_mem_read, ex_reg_write, ex_rd, ex_mdu_op, pc_offset,
    output pc_hold, if_hold, id_bubble, ex_hold, mdu_busy, mdu_remaining
`ifdef HAZARD_STATS_EN
    , output stat_lu_stalls, stat_mdu_stalls, stat_flushes
`endif
  );
  modport master (
    output id_no_op, id_rs, id_rt, id_uses_rs, id_uses_rt,
    output ex_mem_read, ex_reg_write, ex_rd, ex_mdu_op, pc_offset,
    input  pc_hold, if_hold, id_bubble, ex_hold, mdu_busy, mdu_remaining
`ifdef HAZARD_STATS_EN
    , input stat_lu_stalls, stat_mdu_stalls, stat_flushes
`endif
  );
endinterface

// File: rtl/hazard_lu_detect.sv
// hazard_lu_detect: combinational load-use comparator between ID sources and an EX load destination
module hazard_lu_detect
  import hazard_ctrl_pkg::*;
(
  input  logic      id_no_op_i,
  input  reg_addr_t id_rs_i,
  input  reg_addr_t id_rt_i,
  input  logic      id_uses_rs_i,
  input  logic      id_uses_rt_i,
  input  logic      ex_mem_read_i,
  input  logic      ex_reg_write_i,
  input  reg_addr_t ex_rd_i,
  output logic      lu_o
);
  assign lu_o = ex_mem_read_i & ex_reg_write_i & (ex_rd_i != '0) & ~id_no_op_i &
                ((id_uses_rs_i & (id_rs_i == ex_rd_i)) | (id_uses_rt_i & (id_rt_i == ex_rd_i)));
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush sequencer with MDU occupancy FSM; HAZARD_STATS_EN adds stall/flush counters
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MDU_CYCLES = 32,
  parameter int CNT_WIDTH  = 8
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);
  hz_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 busy_q;
  logic                 lu, run, busy, mdu_go, lu_stall;
  hazard_lu_detect u_lu (
    .id_no_op_i     (hz.id_no_op),
    .id_rs_i        (hz.id_rs),
    .id_rt_i        (hz.id_rt),
    .id_uses_rs_i   (hz.id_uses_rs),
    .id_uses_rt_i   (hz.id_uses_rt),
    .ex_mem_read_i  (hz.ex_mem_read),
    .ex_reg_write_i (hz.ex_reg_write),
    .ex_rd_i        (hz.ex_rd),
    .lu_o           (lu)
  );
  // Stall priority: branch redirect, then MDU start, then load-use; MDU_DONE still honours load-use
  always_comb begin
    run      = ~rst & (state_q == HZ_RUN);
    busy     = ~rst & (state_q == HZ_MDU_BUSY);
    mdu_go   = run & ~hz.pc_offset & hz.ex_mdu_op;
    lu_stall = lu & ((run & ~hz.pc_offset & ~hz.ex_mdu_op) | (~rst & (state_q == HZ_MDU_DONE)));
    state_d  = mdu_go ? HZ_MDU_BUSY :
               (state_q == HZ_MDU_BUSY) ? ((cnt_q != '0) ? HZ_MDU_BUSY : HZ_MDU_DONE) : HZ_RUN;
    cnt_d    = mdu_go ? CNT_WIDTH'(MDU_CYCLES - 2) : (busy && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  end
  // FSM state, MDU down-counter and registered busy flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HZ_RUN;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == HZ_MDU_BUSY);
    end
  end
  assign hz.pc_hold       = mdu_go | busy | lu_stall;
  assign hz.if_hold       = mdu_go | busy | lu_stall;
  assign hz.id_bubble     = lu_stall;
  assign hz.ex_hold       = mdu_go | busy;
  assign hz.mdu_busy      = busy_q;
  assign hz.mdu_remaining = cnt_q;
`ifdef HAZARD_STATS_EN
  logic [31:0] lu_cnt_q, mdu_cnt_q, fl_cnt_q;
  // Saturating per-cause cycle counters; MDU stalls count the busy-state cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt_q  <= '0;
      mdu_cnt_q <= '0;
      fl_cnt_q  <= '0;
    end else begin
      lu_cnt_q  <= sat_inc(lu_cnt_q, lu_stall);
      mdu_cnt_q <= sat_inc(mdu_cnt_q, busy);
      fl_cnt_q  <= sat_inc(fl_cnt_q, run & hz.pc_offset);
    end
  end
  assign hz.stat_lu_stalls  = lu_cnt_q;
  assign hz.stat_mdu_stalls = mdu_cnt_q;
  assign hz.stat_flushes    = fl_cnt_q;
`endif
endmodule
